// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: sequences fetch/decode/execute and drives every datapath enable/select.
// Build option: define OVERFLOW_TRAP_EN to trap add/sub/addi overflow through EPC (EXC_OVF state).
module controle_multiciclo #(
  parameter int MEM_WAIT = 1,
  parameter int SP_INIT  = 227
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Of,
  input  logic       Eq,
  output logic       PC_w,
  output logic       MEM_w,
  output logic       IR_w,
  output logic       RB_w,
  output logic       AB_w,
  output logic       ALU_w,
  output logic       EPC_w,
  output logic [2:0] ULA_c,
  output logic [1:0] M_selector_Memory,
  output logic [1:0] M_selector_writereg,
  output logic [2:0] M_selector_WDATA,
  output logic       M_selector_A,
  output logic [1:0] M_selector_B,
  output logic [1:0] M_selector_PC,
  output logic [4:0] estado
);

  // SP_INIT itself lives in the datapath; WDATA select 7 routes it during RST.
  if (MEM_WAIT < 1 || MEM_WAIT > 3 || SP_INIT < 0) begin : g_param_check
    $error("controle_multiciclo: MEM_WAIT must be 1..3 and SP_INIT non-negative");
  end

  localparam logic [1:0] MW    = 2'(MEM_WAIT);
  localparam logic [1:0] MW_M1 = 2'(MEM_WAIT - 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  typedef enum logic [4:0] {
    RST     = 5'd0,
    FETCH   = 5'd1,
    WAIT_F  = 5'd2,
    IR_LD   = 5'd3,
    DECODE  = 5'd4,
    R_EX    = 5'd5,
    R_WB    = 5'd6,
    ADDI_EX = 5'd7,
    I_WB    = 5'd8,
    ADDR    = 5'd9,
    MEM_RD  = 5'd10,
    LW_WB   = 5'd11,
    MEM_WR  = 5'd12,
    BR      = 5'd13,
    JMP     = 5'd14,
    JAL_LD  = 5'd15,
    JAL_J   = 5'd16,
    EXC_OP  = 5'd17,
    EXC_MEM = 5'd18,
    EXC_PC  = 5'd19
`ifdef OVERFLOW_TRAP_EN
    , EXC_OVF = 5'd20
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  assign estado = state_q;

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q, ovf_d;

  // Overflow is captured at the edge leaving the execute state so writeback can veto itself.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ADDI_EX) ovf_d = Of;
    else if (state_q == R_EX) ovf_d = Of && (FUNCT != FN_AND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
`else
  logic unused_of;
  assign unused_of = Of;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:     state_d = FETCH;
      FETCH:   state_d = WAIT_F;
      WAIT_F:  if (cnt_q == MW_M1) state_d = IR_LD;
      IR_LD:   state_d = DECODE;
      DECODE: begin
        case (OPCODE)
          OP_R:          state_d = (FUNCT == FN_ADD || FUNCT == FN_SUB || FUNCT == FN_AND)
                                   ? R_EX : EXC_OP;
          OP_ADDI:       state_d = ADDI_EX;
          OP_LW, OP_SW:  state_d = ADDR;
          OP_BEQ,OP_BNE: state_d = BR;
          OP_J:          state_d = JMP;
          OP_JAL:        state_d = JAL_LD;
          default:       state_d = EXC_OP;
        endcase
      end
      R_EX:    state_d = R_WB;
      ADDI_EX: state_d = I_WB;
`ifdef OVERFLOW_TRAP_EN
      R_WB, I_WB: state_d = ovf_q ? EXC_OVF : FETCH;
      EXC_OVF: state_d = EXC_MEM;
`else
      R_WB, I_WB: state_d = FETCH;
`endif
      ADDR:    state_d = (OPCODE == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  if (cnt_q == MW) state_d = LW_WB;
      LW_WB:   state_d = FETCH;
      MEM_WR:  state_d = FETCH;
      BR:      state_d = FETCH;
      JMP:     state_d = FETCH;
      JAL_LD:  state_d = JAL_J;
      JAL_J:   state_d = FETCH;
      EXC_OP:  state_d = EXC_MEM;
      EXC_MEM: if (cnt_q == MW) state_d = EXC_PC;
      EXC_PC:  state_d = FETCH;
      default: state_d = RST;
    endcase
  end

  // Wait states leave on a cycle count; the counter restarts on every state change.
  assign cnt_d = (state_d == state_q) ? cnt_q + 2'd1 : 2'd0;

  always_comb begin
    PC_w = 1'b0; MEM_w = 1'b0; IR_w = 1'b0; RB_w = 1'b0;
    AB_w = 1'b0; ALU_w = 1'b0; EPC_w = 1'b0;
    ULA_c = 3'b000;
    M_selector_Memory = 2'd0; M_selector_writereg = 2'd0; M_selector_WDATA = 3'd0;
    M_selector_A = 1'b0; M_selector_B = 2'd0; M_selector_PC = 2'd0;
    if (!reset) begin
      case (state_q)
        RST:     begin RB_w = 1'b1; M_selector_writereg = 2'd2; M_selector_WDATA = 3'd7; end
        FETCH:   begin M_selector_B = 2'd1; ULA_c = 3'b001; PC_w = 1'b1; end
        IR_LD:   IR_w = 1'b1;
        DECODE:  begin AB_w = 1'b1; M_selector_B = 2'd3; ULA_c = 3'b001; ALU_w = 1'b1; end
        R_EX: begin
          M_selector_A = 1'b1; ALU_w = 1'b1;
          ULA_c = (FUNCT == FN_SUB) ? 3'b010 : (FUNCT == FN_AND) ? 3'b011 : 3'b001;
        end
        R_WB: begin
          M_selector_writereg = 2'd1;
`ifdef OVERFLOW_TRAP_EN
          RB_w = !ovf_q;
`else
          RB_w = 1'b1;
`endif
        end
        ADDI_EX, ADDR: begin
          M_selector_A = 1'b1; M_selector_B = 2'd2; ULA_c = 3'b001; ALU_w = 1'b1;
        end
        I_WB: begin
`ifdef OVERFLOW_TRAP_EN
          RB_w = !ovf_q;
`else
          RB_w = 1'b1;
`endif
        end
        MEM_RD:  M_selector_Memory = 2'd1;
        LW_WB:   begin M_selector_Memory = 2'd1; M_selector_WDATA = 3'd1; RB_w = 1'b1; end
        MEM_WR:  begin M_selector_Memory = 2'd1; MEM_w = 1'b1; end
        BR: begin
          M_selector_A = 1'b1; ULA_c = 3'b111; M_selector_PC = 2'd1;
          PC_w = (OPCODE == OP_BEQ) ? Eq : !Eq;
        end
        JMP:     begin M_selector_PC = 2'd2; PC_w = 1'b1; end
        JAL_LD:  ALU_w = 1'b1;
        JAL_J: begin
          RB_w = 1'b1; M_selector_writereg = 2'd3; M_selector_PC = 2'd2; PC_w = 1'b1;
        end
`ifdef OVERFLOW_TRAP_EN
        EXC_OVF: begin EPC_w = 1'b1; ULA_c = 3'b010; M_selector_B = 2'd1; end
`endif
        EXC_OP:  begin EPC_w = 1'b1; ULA_c = 3'b010; M_selector_B = 2'd1; end
        EXC_MEM: M_selector_Memory = 2'd2;
        EXC_PC:  begin M_selector_Memory = 2'd2; M_selector_PC = 2'd3; PC_w = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: instance a uses MEM_WAIT=1, instance b MEM_WAIT=2.
module tb_controle_multiciclo;

  localparam logic [4:0] S_RST = 0, S_FETCH = 1, S_WAIT_F = 2, S_IR_LD = 3, S_DECODE = 4,
    S_R_EX = 5, S_R_WB = 6, S_ADDI_EX = 7, S_I_WB = 8, S_ADDR = 9, S_MEM_RD = 10,
    S_LW_WB = 11, S_MEM_WR = 12, S_BR = 13, S_JMP = 14, S_JAL_LD = 15, S_JAL_J = 16,
    S_EXC_OP = 17, S_EXC_MEM = 18, S_EXC_PC = 19, S_EXC_OVF = 20;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic of_in, eq_in;

  logic pc_w, mem_w, ir_w, rb_w, ab_w, alu_w, epc_w, sel_a;
  logic [2:0] ula_c, sel_wd;
  logic [1:0] sel_mem, sel_wr, sel_b, sel_pc;
  logic [4:0] estado;

  logic b_pc_w, b_mem_w, b_ir_w, b_rb_w, b_ab_w, b_alu_w, b_epc_w, b_sel_a;
  logic [2:0] b_ula_c, b_sel_wd;
  logic [1:0] b_sel_mem, b_sel_wr, b_sel_b, b_sel_pc;
  logic [4:0] b_estado;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  controle_multiciclo #(.MEM_WAIT(1), .SP_INIT(227)) dut (
    .clk(clk), .reset(reset), .OPCODE(opcode), .FUNCT(funct), .Of(of_in), .Eq(eq_in),
    .PC_w(pc_w), .MEM_w(mem_w), .IR_w(ir_w), .RB_w(rb_w), .AB_w(ab_w), .ALU_w(alu_w),
    .EPC_w(epc_w), .ULA_c(ula_c), .M_selector_Memory(sel_mem), .M_selector_writereg(sel_wr),
    .M_selector_WDATA(sel_wd), .M_selector_A(sel_a), .M_selector_B(sel_b),
    .M_selector_PC(sel_pc), .estado(estado)
  );

  controle_multiciclo #(.MEM_WAIT(2), .SP_INIT(227)) dut_b (
    .clk(clk), .reset(reset), .OPCODE(opcode), .FUNCT(funct), .Of(of_in), .Eq(eq_in),
    .PC_w(b_pc_w), .MEM_w(b_mem_w), .IR_w(b_ir_w), .RB_w(b_rb_w), .AB_w(b_ab_w),
    .ALU_w(b_alu_w), .EPC_w(b_epc_w), .ULA_c(b_ula_c), .M_selector_Memory(b_sel_mem),
    .M_selector_writereg(b_sel_wr), .M_selector_WDATA(b_sel_wd), .M_selector_A(b_sel_a),
    .M_selector_B(b_sel_b), .M_selector_PC(b_sel_pc), .estado(b_estado)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic of_v, input logic eq_v);
    opcode = op; funct = fn; of_in = of_v; eq_in = eq_v;
  endtask

  // From FETCH through DECODE on instance a; returns one cycle after DECODE.
  task automatic fetch_seq(input string tag);
    check({tag, "_fetch"}, estado, S_FETCH);
    check({tag, "_fetch_pcw"}, pc_w, 1);
    check({tag, "_fetch_selb"}, sel_b, 1);
    check({tag, "_fetch_mem_w"}, mem_w, 0);
    tick();
    check({tag, "_waitf"}, estado, S_WAIT_F);
    check({tag, "_waitf_pcw"}, pc_w, 0);
    tick();
    check({tag, "_irld"}, estado, S_IR_LD);
    check({tag, "_irld_irw"}, ir_w, 1);
    tick();
    check({tag, "_decode"}, estado, S_DECODE);
    check({tag, "_decode_abw"}, ab_w, 1);
    check({tag, "_decode_selb"}, sel_b, 3);
    check({tag, "_decode_aluw"}, alu_w, 1);
    tick();
  endtask

  task automatic exc_seq(input string tag, input logic [4:0] first);
    check({tag, "_exc"}, estado, first);
    check({tag, "_exc_epcw"}, epc_w, 1);
    check({tag, "_exc_ula"}, ula_c, 3'b010);
    check({tag, "_exc_sela"}, sel_a, 0);
    check({tag, "_exc_selb"}, sel_b, 1);
    check({tag, "_exc_rbw"}, rb_w, 0);
    tick();
    check({tag, "_excmem1"}, estado, S_EXC_MEM);
    check({tag, "_excmem1_sel"}, sel_mem, 2);
    check({tag, "_excmem1_epcw"}, epc_w, 0);
    tick();
    check({tag, "_excmem2"}, estado, S_EXC_MEM);
    tick();
    check({tag, "_excpc"}, estado, S_EXC_PC);
    check({tag, "_excpc_pcw"}, pc_w, 1);
    check({tag, "_excpc_selpc"}, sel_pc, 3);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    set_instr(6'h00, 6'h20, 1'b0, 1'b0);
    #12;
    check("rst_hold_state", estado, S_RST);
    check("rst_hold_rbw", rb_w, 0);
    check("rst_hold_pcw", pc_w, 0);
    reset = 1'b0;
    #1;
    check("rst_state", estado, S_RST);
    check("rst_rbw", rb_w, 1);
    check("rst_wr", sel_wr, 2);
    check("rst_wd", sel_wd, 7);
    tick();

    // add $3,$1,$2
    fetch_seq("add");
    check("add_rex", estado, S_R_EX);
    check("add_rex_ula", ula_c, 3'b001);
    check("add_rex_sela", sel_a, 1);
    check("add_rex_rbw", rb_w, 0);
    tick();
    check("add_rwb", estado, S_R_WB);
    check("add_rwb_rbw", rb_w, 1);
    check("add_rwb_wr", sel_wr, 1);
    check("add_rwb_wd", sel_wd, 0);
    tick();

    set_instr(6'h00, 6'h22, 1'b0, 1'b0);
    fetch_seq("sub");
    check("sub_rex_ula", ula_c, 3'b010);
    tick();
    check("sub_rwb_rbw", rb_w, 1);
    tick();

    // and never overflows, even with the flag raised
    set_instr(6'h00, 6'h24, 1'b1, 1'b0);
    fetch_seq("and");
    check("and_rex_ula", ula_c, 3'b011);
    tick();
    check("and_rwb", estado, S_R_WB);
    check("and_rwb_rbw", rb_w, 1);
    tick();

    set_instr(6'h08, 6'h00, 1'b1, 1'b0);
    fetch_seq("addi_ovf");
    check("addi_ex", estado, S_ADDI_EX);
    check("addi_ex_selb", sel_b, 2);
    check("addi_ex_ula", ula_c, 3'b001);
    tick();
    check("addi_iwb", estado, S_I_WB);
`ifdef OVERFLOW_TRAP_EN
    check("addi_iwb_rbw", rb_w, 0);
    tick();
    exc_seq("addi_ovf", S_EXC_OVF);
`else
    check("addi_iwb_rbw", rb_w, 1);
    check("addi_iwb_wr", sel_wr, 0);
    tick();
`endif

    set_instr(6'h04, 6'h00, 1'b0, 1'b1);
    fetch_seq("beq_t");
    check("beq_t_br", estado, S_BR);
    check("beq_t_pcw", pc_w, 1);
    check("beq_t_selpc", sel_pc, 1);
    check("beq_t_ula", ula_c, 3'b111);
    tick();

    set_instr(6'h05, 6'h00, 1'b0, 1'b1);
    fetch_seq("bne_nt");
    check("bne_nt_pcw", pc_w, 0);
    tick();

    set_instr(6'h05, 6'h00, 1'b0, 1'b0);
    fetch_seq("bne_t");
    check("bne_t_pcw", pc_w, 1);
    tick();

    set_instr(6'h02, 6'h00, 1'b0, 1'b0);
    fetch_seq("j");
    check("j_jmp", estado, S_JMP);
    check("j_pcw", pc_w, 1);
    check("j_selpc", sel_pc, 2);
    tick();

    set_instr(6'h03, 6'h00, 1'b0, 1'b0);
    fetch_seq("jal");
    check("jal_ld", estado, S_JAL_LD);
    check("jal_ld_aluw", alu_w, 1);
    check("jal_ld_ula", ula_c, 3'b000);
    check("jal_ld_rbw", rb_w, 0);
    tick();
    check("jal_j", estado, S_JAL_J);
    check("jal_j_rbw", rb_w, 1);
    check("jal_j_wr", sel_wr, 3);
    check("jal_j_pcw", pc_w, 1);
    check("jal_j_selpc", sel_pc, 2);
    tick();

    set_instr(6'h3f, 6'h00, 1'b0, 1'b0);
    fetch_seq("badop");
    exc_seq("badop", S_EXC_OP);

    set_instr(6'h00, 6'h21, 1'b0, 1'b0);
    fetch_seq("badfn");
    exc_seq("badfn", S_EXC_OP);

    set_instr(6'h2b, 6'h00, 1'b0, 1'b0);
    fetch_seq("sw");
    check("sw_addr", estado, S_ADDR);
    check("sw_addr_selb", sel_b, 2);
    tick();
    check("sw_memwr", estado, S_MEM_WR);
    check("sw_memw", mem_w, 1);
    check("sw_selmem", sel_mem, 1);
    tick();
    check("sw_after_memw", mem_w, 0);

    fetch_seq("sw_rst");
    tick();
    check("sw_rst_memwr", estado, S_MEM_WR);
    check("sw_rst_memw_pre", mem_w, 1);
    #1 reset = 1'b1;
    #1;
    check("sw_rst_memw", mem_w, 0);
    check("sw_rst_state", estado, S_RST);
    check("sw_rst_state_b", b_estado, S_RST);
    reset = 1'b0;
    #1;
    check("sw_rst_rel_rbw", rb_w, 1);
    tick();

    // lw on the MEM_WAIT=2 instance
    set_instr(6'h23, 6'h00, 1'b0, 1'b0);
    check("lw_fetch", b_estado, S_FETCH);
    tick();
    check("lw_waitf1", b_estado, S_WAIT_F);
    tick();
    check("lw_waitf2", b_estado, S_WAIT_F);
    tick();
    check("lw_irld", b_estado, S_IR_LD);
    tick();
    check("lw_decode", b_estado, S_DECODE);
    tick();
    check("lw_addr", b_estado, S_ADDR);
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lw_memrd%0d", i), b_estado, S_MEM_RD);
      check($sformatf("lw_memrd%0d_sel", i), b_sel_mem, 1);
      check($sformatf("lw_memrd%0d_rbw", i), b_rb_w, 0);
      tick();
    end
    check("lw_wb", b_estado, S_LW_WB);
    check("lw_wb_rbw", b_rb_w, 1);
    check("lw_wb_wd", b_sel_wd, 1);
    check("lw_wb_wr", b_sel_wr, 0);
    tick();
    check("lw_back_fetch", b_estado, S_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
